door_access_scheduler: RTL

- Access scheduler for the single revolving-door passage on the DE2 board.
- Debounces the three door switches and arbitrates the shared turnstile between entry and exit requesters. Entry and exit take turns when both are pending.
- Times each passage, enforces a metal-detector lockout, and tracks building occupancy.
- Drives the LEDG/LEDR door indicators. Occupancy goes out on a 4-bit port for the display block.

---
 rtl/door_access_scheduler.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/door_access_scheduler.sv
// Revolving-door access scheduler.
// Conditions the three door switches, arbitrates the turnstile between entry
// and exit (alternating when both wait), times each passage, holds the door
// locked after a metal alarm and keeps the building occupancy count.
module door_access_scheduler #(
    parameter int DEB_CYC   = 270000,
    parameter int PASS_TIME = 135000000,
    parameter int LOCK_TIME = 81000000,
    parameter int MAX_OCC   = 15
) (
    input  logic       CLOCK_27,
    input  logic [0:0] KEY,
    input  logic [2:0] SW,
    output logic [1:0] LEDG,
    output logic [3:0] LEDR,
    output logic [3:0] OCC
);

    // Debounce counter only needs to reach DEB_CYC-1.
    localparam int DW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    // One shared timer serves both the pass window and the lockout.
    localparam int TMAX = (PASS_TIME > LOCK_TIME) ? PASS_TIME : LOCK_TIME;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_GRANT_IN  = 2'd1;
    localparam logic [1:0] ST_GRANT_OUT = 2'd2;
    localparam logic [1:0] ST_ALARM     = 2'd3;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    logic                rst_meta_r;
    logic                rst_sync_r;
    logic                rst_n_s;

    logic [2:0]          sw_meta_r;
    logic [2:0]          sw_sync_r;
    logic [2:0]          deb_r;
    logic [2:0][DW-1:0]  deb_cnt_r;

    logic                d_m_s;
    logic                d_x_s;
    logic                d_e_s;
    logic                want_in_s;

    logic [1:0]          state_r;
    logic [1:0]          state_nx_s;
    logic                last_r;
    logic                last_nx_s;
    logic [TW-1:0]       timer_r;
    logic [TW-1:0]       timer_nx_s;
    logic [3:0]          occ_r;
    logic [3:0]          occ_nx_s;

    // Reset asserts immediately with KEY[0] and releases two clocks later.
    always_ff @(posedge CLOCK_27 or negedge KEY[0]) begin
        if (!KEY[0]) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    assign rst_n_s = rst_sync_r;

    // Two-flop synchronizer for the asynchronous door switches.
    always_ff @(posedge CLOCK_27 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sw_meta_r <= 3'b000;
            sw_sync_r <= 3'b000;
        end else begin
            sw_meta_r <= SW;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Per-bit debounce: accept a new level only after DEB_CYC differing cycles.
    always_ff @(posedge CLOCK_27 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            deb_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_r[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sw_sync_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= {DW{1'b0}};
                end else if (deb_cnt_r[i] == DW'(DEB_CYC - 1)) begin
                    deb_r[i]     <= sw_sync_r[i];
                    deb_cnt_r[i] <= {DW{1'b0}};
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1'b1);
                end
            end
        end
    end

    assign d_m_s     = deb_r[0];
    assign d_x_s     = deb_r[1];
    assign d_e_s     = deb_r[2];
    assign want_in_s = d_e_s && (occ_r < 4'(MAX_OCC));

    // Next-state, timer, direction memory and occupancy update.
    always_comb begin
        state_nx_s = state_r;
        last_nx_s  = last_r;
        timer_nx_s = timer_r;
        occ_nx_s   = occ_r;
        case (state_r)
            ST_IDLE: begin
                if (want_in_s && d_x_s) begin
                    // Both pending: serve the direction not served last time.
                    if (last_r == DIR_IN) begin
                        state_nx_s = ST_GRANT_OUT;
                        last_nx_s  = DIR_OUT;
                    end else begin
                        state_nx_s = ST_GRANT_IN;
                        last_nx_s  = DIR_IN;
                    end
                    timer_nx_s = TW'(PASS_TIME - 1);
                end else if (want_in_s) begin
                    state_nx_s = ST_GRANT_IN;
                    last_nx_s  = DIR_IN;
                    timer_nx_s = TW'(PASS_TIME - 1);
                end else if (d_x_s) begin
                    state_nx_s = ST_GRANT_OUT;
                    last_nx_s  = DIR_OUT;
                    timer_nx_s = TW'(PASS_TIME - 1);
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_GRANT_IN: begin
                if (d_m_s) begin
                    state_nx_s = ST_ALARM;
                    last_nx_s  = DIR_IN;
                    timer_nx_s = TW'(LOCK_TIME - 1);
                end else if (!d_e_s) begin
                    state_nx_s = ST_IDLE;
                    if (occ_r < 4'(MAX_OCC)) begin
                        occ_nx_s = occ_r + 4'd1;
                    end else begin
                        occ_nx_s = occ_r;
                    end
                end else if (timer_r == {TW{1'b0}}) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    timer_nx_s = timer_r - TW'(1'b1);
                end
            end
            ST_GRANT_OUT: begin
                if (!d_x_s) begin
                    state_nx_s = ST_IDLE;
                    if (occ_r != 4'd0) begin
                        occ_nx_s = occ_r - 4'd1;
                    end else begin
                        occ_nx_s = 4'd0;
                    end
                end else if (timer_r == {TW{1'b0}}) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    timer_nx_s = timer_r - TW'(1'b1);
                end
            end
            ST_ALARM: begin
                // Lock holds until the timer expires and the doorway is clear.
                if (timer_r != {TW{1'b0}}) begin
                    timer_nx_s = timer_r - TW'(1'b1);
                end else if (!d_m_s && !d_e_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    timer_nx_s = {TW{1'b0}};
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                timer_nx_s = {TW{1'b0}};
            end
        endcase
    end

    // Scheduler state registers.
    always_ff @(posedge CLOCK_27 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= ST_IDLE;
            last_r  <= DIR_IN;
            timer_r <= {TW{1'b0}};
            occ_r   <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            last_r  <= last_nx_s;
            timer_r <= timer_nx_s;
            occ_r   <= occ_nx_s;
        end
    end

    assign LEDG = {(state_r == ST_GRANT_OUT), (state_r == ST_GRANT_IN)};
    assign LEDR = {(state_r == ST_ALARM), (state_r == ST_ALARM),
                   (state_r != ST_GRANT_OUT), (state_r != ST_GRANT_IN)};
    assign OCC  = occ_r;

endmodule
